// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding unit:
// forwarding select codes, Tuse/Tnew values, register field positions, scoreboard record.
package hazard_scoreboard_pkg;

  localparam int REG_W_P    = 5;
  localparam int LINK_REG_P = 31;
  localparam int FWD_W_P    = 2;

  localparam logic [FWD_W_P-1:0] FWD_NONE   = 2'd0;
  localparam logic [FWD_W_P-1:0] FWD_FROM_W = 2'd1;
  localparam logic [FWD_W_P-1:0] FWD_FROM_M = 2'd2;
  localparam logic [FWD_W_P-1:0] FWD_FROM_E = 2'd3;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  typedef struct packed {
    logic [REG_W_P-1:0] rs;
    logic [REG_W_P-1:0] rt;
    logic [REG_W_P-1:0] dest;
    logic [1:0]         tnew;
  } sb_rec_t;

  localparam sb_rec_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_decode.sv
// Maps the ID instruction and its class flags to register fields, destination,
// operand use times and result-ready time at E entry. Purely combinational.
module hazard_decode
  import hazard_scoreboard_pkg::*;
#(
  parameter int LINK_REG = LINK_REG_P
) (
  input  logic [31:0]        i_instr,
  input  logic               i_rtype,
  input  logic               i_itype,
  input  logic               i_load,
  input  logic               i_save,
  input  logic               i_beq,
  input  logic               i_jal,
  input  logic               i_jr,
  output logic [REG_W_P-1:0] o_rs,
  output logic [REG_W_P-1:0] o_rt,
  output logic [REG_W_P-1:0] o_dest,
  output logic [1:0]         o_tuse_rs,
  output logic [1:0]         o_tuse_rt,
  output logic [1:0]         o_tnew
);

  logic w_unused_bits;
  assign w_unused_bits = ^{i_instr[31:RS_LSB+REG_W_P], i_instr[RD_LSB-1:0]};

  assign o_rs = i_instr[RS_LSB +: REG_W_P];
  assign o_rt = i_instr[RT_LSB +: REG_W_P];

  always_comb begin
    o_dest    = '0;
    o_tuse_rs = TUSE_NONE;
    o_tuse_rt = TUSE_NONE;
    o_tnew    = TNEW_0;

    if (i_rtype)               o_dest = i_instr[RD_LSB +: REG_W_P];
    else if (i_itype | i_load) o_dest = i_instr[RT_LSB +: REG_W_P];
    else if (i_jal)            o_dest = REG_W_P'(LINK_REG);

    if (i_beq | i_jr)                              o_tuse_rs = TUSE_0;
    else if (i_rtype | i_itype | i_load | i_save)  o_tuse_rs = TUSE_1;

    if (i_beq)       o_tuse_rt = TUSE_0;
    else if (i_rtype) o_tuse_rt = TUSE_1;
    else if (i_save)  o_tuse_rt = TUSE_2;

    // jal's link value is ready as it enters E, so it keeps TNEW_0
    if (i_load)                 o_tnew = TNEW_2;
    else if (i_rtype | i_itype) o_tnew = TNEW_1;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall and forwarding-select generation from an internal E/M/W scoreboard
// of in-flight writers; outputs are combinational, scoreboard advances each clock.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W    = REG_W_P,
  parameter int LINK_REG = LINK_REG_P,
  parameter int FWD_W    = FWD_W_P
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr_ID,
  input  logic             Rtype,
  input  logic             Itype,
  input  logic             load,
  input  logic             save,
  input  logic             beq,
  input  logic             jal,
  input  logic             jr,
  output logic             stall,
  output logic [FWD_W-1:0] FwdRS_ID,
  output logic [FWD_W-1:0] FwdRT_ID,
  output logic [FWD_W-1:0] FwdRS_E,
  output logic [FWD_W-1:0] FwdRT_E,
  output logic [FWD_W-1:0] FwdRT_M
);

  sb_rec_t r_e, r_m, r_w;
  sb_rec_t w_id, w_e_nxt, w_m_nxt, w_w_nxt;
  logic [REG_W-1:0] w_rs, w_rt, w_dest;
  logic [1:0]       w_tuse_rs, w_tuse_rt, w_tnew;

  hazard_decode #(.LINK_REG(LINK_REG)) u_decode (
    .i_instr  (Instr_ID),
    .i_rtype  (Rtype),
    .i_itype  (Itype),
    .i_load   (load),
    .i_save   (save),
    .i_beq    (beq),
    .i_jal    (jal),
    .i_jr     (jr),
    .o_rs     (w_rs),
    .o_rt     (w_rt),
    .o_dest   (w_dest),
    .o_tuse_rs(w_tuse_rs),
    .o_tuse_rt(w_tuse_rt),
    .o_tnew   (w_tnew)
  );

  function automatic logic hazard(input logic [REG_W-1:0] r, input logic [1:0] tuse,
                                  input sb_rec_t s);
    return (tuse != TUSE_NONE) && (r != '0) && (r == s.dest) && (tuse < s.tnew);
  endfunction

  // Nearest matching stage decides; a match still waiting on its result yields
  // FWD_NONE and hides older stages so a stale value is never picked.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] r,
                                               input sb_rec_t e, input sb_rec_t m,
                                               input sb_rec_t w,
                                               input logic en_e, input logic en_m);
    logic [FWD_W-1:0] sel;
    sel = FWD_NONE;
    if (r == '0)                      sel = FWD_NONE;
    else if (en_e && (e.dest == r))   sel = (e.tnew == TNEW_0) ? FWD_FROM_E : FWD_NONE;
    else if (en_m && (m.dest == r))   sel = (m.tnew == TNEW_0) ? FWD_FROM_M : FWD_NONE;
    else if (w.dest == r)             sel = FWD_FROM_W;
    return sel;
  endfunction

  assign w_id = '{rs: w_rs, rt: w_rt, dest: w_dest, tnew: w_tnew};

  assign stall = hazard(w_rs, w_tuse_rs, r_e) | hazard(w_rt, w_tuse_rt, r_e) |
                 hazard(w_rs, w_tuse_rs, r_m) | hazard(w_rt, w_tuse_rt, r_m);

  assign FwdRS_ID = fwd_sel(w_rs, r_e, r_m, r_w, 1'b1, 1'b1);
  assign FwdRT_ID = fwd_sel(w_rt, r_e, r_m, r_w, 1'b1, 1'b1);
  assign FwdRS_E  = fwd_sel(r_e.rs, r_e, r_m, r_w, 1'b0, 1'b1);
  assign FwdRT_E  = fwd_sel(r_e.rt, r_e, r_m, r_w, 1'b0, 1'b1);
  assign FwdRT_M  = fwd_sel(r_m.rt, r_e, r_m, r_w, 1'b0, 1'b0);

  always_comb begin
    w_e_nxt = stall ? SB_BUBBLE : w_id;
    w_m_nxt = r_e;
    w_m_nxt.tnew = (r_e.tnew == TNEW_0) ? TNEW_0 : r_e.tnew - 2'd1;
    w_w_nxt = r_m;
    w_w_nxt.tnew = TNEW_0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_e <= SB_BUBBLE;
      r_m <= SB_BUBBLE;
      r_w <= SB_BUBBLE;
    end else begin
      r_e <= w_e_nxt;
      r_m <= w_m_nxt;
      r_w <= w_w_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table of per-cycle ID inputs with hand-computed stall/select values,
// plus explicit reset-state and reset-during-stall sequences.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_ID;
  logic        Rtype, Itype, load, save, beq, jal, jr;
  logic        stall;
  logic [1:0]  FwdRS_ID, FwdRT_ID, FwdRS_E, FwdRT_E, FwdRT_M;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk     (clk),
    .reset   (reset),
    .Instr_ID(Instr_ID),
    .Rtype   (Rtype),
    .Itype   (Itype),
    .load    (load),
    .save    (save),
    .beq     (beq),
    .jal     (jal),
    .jr      (jr),
    .stall   (stall),
    .FwdRS_ID(FwdRS_ID),
    .FwdRT_ID(FwdRT_ID),
    .FwdRS_E (FwdRS_E),
    .FwdRT_E (FwdRT_E),
    .FwdRT_M (FwdRT_M)
  );

  // flag order {Rtype, Itype, load, save, beq, jal, jr}
  localparam logic [6:0] F_N  = 7'b0000000;
  localparam logic [6:0] F_R  = 7'b1000000;
  localparam logic [6:0] F_I  = 7'b0100000;
  localparam logic [6:0] F_L  = 7'b0010000;
  localparam logic [6:0] F_S  = 7'b0001000;
  localparam logic [6:0] F_B  = 7'b0000100;
  localparam logic [6:0] F_J  = 7'b0000010;
  localparam logic [6:0] F_JR = 7'b0000001;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  fl;
    logic        st;
    logic [1:0]  rs_id, rt_id, rs_e, rt_e, rt_m;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  task automatic add(input logic [31:0] ins, input logic [6:0] fl, input logic st,
                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                     input logic [1:0] d, input logic [1:0] e);
    vec_t v;
    v.instr = ins; v.fl = fl; v.st = st;
    v.rs_id = a; v.rt_id = b; v.rs_e = c; v.rt_e = d; v.rt_m = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [6:0] fl);
    Instr_ID = ins;
    {Rtype, Itype, load, save, beq, jal, jr} = fl;
  endtask

  task automatic chk(input string nm, input int idx, input logic [1:0] act,
                     input logic [1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
  endtask

  task automatic check_all(input int idx, input logic st, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] c,
                           input logic [1:0] d, input logic [1:0] e);
    chk("stall",    idx, {1'b0, stall}, {1'b0, st});
    chk("FwdRS_ID", idx, FwdRS_ID, a);
    chk("FwdRT_ID", idx, FwdRT_ID, b);
    chk("FwdRS_E",  idx, FwdRS_E,  c);
    chk("FwdRT_E",  idx, FwdRT_E,  d);
    chk("FwdRT_M",  idx, FwdRT_M,  e);
  endtask

  initial begin
    // lw $8,0($29) ; addu $9,$8,$10 (held through the stall) ; flush
    add(mk(29, 8, 0),  F_L, 0, 0, 0, 0, 0, 0);
    add(mk(8, 10, 9),  F_R, 1, 0, 0, 0, 0, 0);
    add(mk(8, 10, 9),  F_R, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 1, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    // ori $8 ; beq $8,$8 (held) ; flush
    add(mk(0, 8, 0),   F_I, 0, 0, 0, 0, 0, 0);
    add(mk(8, 8, 0),   F_B, 1, 0, 0, 0, 0, 0);
    add(mk(8, 8, 0),   F_B, 0, 2, 2, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 1, 1, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    // jal ; jr $31
    add(mk(0, 0, 0),   F_J, 0, 0, 0, 0, 0, 0);
    add(mk(31, 0, 0),  F_JR,0, 3, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 2, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    // addu $8,$1,$2 ; addu $8,$3,$4 ; addu $9,$8,$8
    add(mk(1, 2, 8),   F_R, 0, 0, 0, 0, 0, 0);
    add(mk(3, 4, 8),   F_R, 0, 0, 0, 0, 0, 0);
    add(mk(8, 8, 9),   F_R, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 2, 2, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 1);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    // lw $8,0($29) ; sw $8,0($9)
    add(mk(29, 8, 0),  F_L, 0, 0, 0, 0, 0, 0);
    add(mk(9, 8, 0),   F_S, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 1);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    // ori $0,$5 ; addu $9,$0,$0
    add(mk(5, 0, 0),   F_I, 0, 0, 0, 0, 0, 0);
    add(mk(0, 0, 9),   F_R, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);
    add(32'd0,         F_N, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    drive(32'd0, F_N);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all(-1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].fl);
      #1;
      check_all(i, vecs[i].st, vecs[i].rs_id, vecs[i].rt_id,
                vecs[i].rs_e, vecs[i].rt_e, vecs[i].rt_m);
    end

    // reset asserted while a lw-use stall is pending
    @(negedge clk);
    drive(mk(29, 8, 0), F_L);
    @(negedge clk);
    drive(mk(8, 10, 9), F_R);
    #1;
    check_all(100, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all(101, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(32'd0, F_N);
    #1;
    check_all(102, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
